// File: rtl/riscv_branch_pkg.sv
// Shared types and constants for the ID-stage branch forwarding/hazard unit.
package riscv_branch_pkg;

  typedef enum logic [3:0] {
    FWD_RR = 4'd0,
    FWD_MM = 4'd1,
    FWD_WW = 4'd2,
    FWD_MR = 4'd3,
    FWD_RM = 4'd4,
    FWD_WR = 4'd5,
    FWD_RW = 4'd8,
    FWD_WM = 4'd9,
    FWD_MW = 4'd10
  } opforward_e;

  typedef enum logic {
    RUN,
    HOLD
  } bh_state_e;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_MEM = 2'd1,
    SRC_WB  = 2'd2
  } fwd_src_e;

  localparam logic [1:0] LD_EX_STALL  = 2'd2;
  localparam logic [1:0] ALU_EX_STALL = 2'd1;
  localparam logic [1:0] LD_MEM_STALL = 2'd1;

  // Pairs the rs1 (a) and rs2 (b) sources into the comparator mux code.
  function automatic opforward_e fwd_encode(input fwd_src_e a, input fwd_src_e b);
    opforward_e code;
    case ({a, b})
      {SRC_MEM, SRC_MEM}: code = FWD_MM;
      {SRC_WB,  SRC_WB }: code = FWD_WW;
      {SRC_MEM, SRC_REG}: code = FWD_MR;
      {SRC_REG, SRC_MEM}: code = FWD_RM;
      {SRC_WB,  SRC_REG}: code = FWD_WR;
      {SRC_REG, SRC_WB }: code = FWD_RW;
      {SRC_WB,  SRC_MEM}: code = FWD_WM;
      {SRC_MEM, SRC_WB }: code = FWD_MW;
      default:            code = FWD_RR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/branch_fwd_decode.sv
// Combinational source matching for early branch resolution: produces the
// operand-forward select and the stall depth needed before the branch can resolve.
module branch_fwd_decode
  import riscv_branch_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_branch_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_memread_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrite_i,
  output logic [1:0]        need_o,
  output logic [3:0]        opforward_o
);

  // x0 is hardwired zero, so it never matches a producer.
  function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs);
    return we && (rd == rs) && (rs != '0);
  endfunction

  function automatic fwd_src_e pick(input logic act, input logic mem_h, input logic wb_h);
    fwd_src_e src;
    src = SRC_REG;
    if (act && mem_h && !mem_memread_i) src = SRC_MEM;
    else if (act && wb_h)               src = SRC_WB;
    return src;
  endfunction

  function automatic logic [1:0] depth(input logic act, input logic ex_h, input logic mem_h);
    logic [1:0] n;
    n = 2'd0;
    if (act) begin
      if (ex_h && ex_memread_i)        n = LD_EX_STALL;
      else if (ex_h)                   n = ALU_EX_STALL;
      else if (mem_h && mem_memread_i) n = LD_MEM_STALL;
    end
    return n;
  endfunction

  logic     act1, act2;
  logic     ex1, mem1, wb1, ex2, mem2, wb2;
  logic [1:0] need1, need2;
  fwd_src_e sel1, sel2;
  opforward_e code;

  assign act1 = id_branch_i;
  assign act2 = id_branch_i && id_use_rs2_i;

  assign ex1  = hit(ex_regwrite_i,  ex_rd_i,  id_rs1_i);
  assign mem1 = hit(mem_regwrite_i, mem_rd_i, id_rs1_i);
  assign wb1  = hit(wb_regwrite_i,  wb_rd_i,  id_rs1_i);
  assign ex2  = hit(ex_regwrite_i,  ex_rd_i,  id_rs2_i);
  assign mem2 = hit(mem_regwrite_i, mem_rd_i, id_rs2_i);
  assign wb2  = hit(wb_regwrite_i,  wb_rd_i,  id_rs2_i);

  assign sel1  = pick(act1, mem1, wb1);
  assign sel2  = pick(act2, mem2, wb2);
  assign need1 = depth(act1, ex1, mem1);
  assign need2 = depth(act2, ex2, mem2);

  assign need_o      = (need1 > need2) ? need1 : need2;
  assign code        = fwd_encode(sel1, sel2);
  assign opforward_o = code;

endmodule

// File: rtl/branch_fwd_hazard_unit.sv
// ID-stage branch hazard unit: forward select, stall/bubble sequencing FSM and,
// with BRANCH_HAZARD_PERF_EN defined, a free-running stall-cycle counter.
module branch_fwd_hazard_unit
  import riscv_branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_branch_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_memread_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrite_i,
  input  logic              flush_i,
  output logic [3:0]        opforward_o,
  output logic              stall_o,
  output logic              bubble_o
`ifdef BRANCH_HAZARD_PERF_EN
  ,
  output logic [XLEN-1:0]   stall_cnt_o
`endif
);

  logic [1:0] need;
  bh_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       stall;

  branch_fwd_decode #(.REG_AW(REG_AW)) u_decode (
    .id_branch_i    (id_branch_i),
    .id_use_rs2_i   (id_use_rs2_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .ex_rd_i        (ex_rd_i),
    .ex_regwrite_i  (ex_regwrite_i),
    .ex_memread_i   (ex_memread_i),
    .mem_rd_i       (mem_rd_i),
    .mem_regwrite_i (mem_regwrite_i),
    .mem_memread_i  (mem_memread_i),
    .wb_rd_i        (wb_rd_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .need_o         (need),
    .opforward_o    (opforward_o)
  );

  // In HOLD the ID instruction is frozen, so only the counter decides the exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (rst_i || flush_i) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          stall = (need != 2'd0);
          if (need == LD_EX_STALL) begin
            state_d = HOLD;
            cnt_d   = LD_EX_STALL - 2'd1;
          end
        end
        HOLD: begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_d == 2'd0) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_o  = stall;
  assign bubble_o = stall;

`ifdef BRANCH_HAZARD_PERF_EN
  // Survives flushes on purpose; only reset clears the count.
  always_ff @(posedge clk_i) begin
    if (rst_i)      stall_cnt_o <= '0;
    else if (stall) stall_cnt_o <= stall_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_branch_fwd_hazard_unit.sv
// Scoreboard bench for branch_fwd_hazard_unit: directed scenarios plus random
// traffic, checked against a stall-budget reference model.
module tb_branch_fwd_hazard_unit;

  typedef struct {
    logic       rst, flush, br, use2;
    logic [4:0] rs1, rs2, exrd;
    logic       exw, exl;
    logic [4:0] memrd;
    logic       memw, meml;
    logic [4:0] wbrd;
    logic       wbw;
  } stim_t;

  typedef struct {
    logic [3:0]  fwd;
    logic        stall;
    logic [31:0] perf;
    logic        chk_perf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i, flush_i, id_branch_i, id_use_rs2_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
  logic ex_regwrite_i, ex_memread_i, mem_regwrite_i, mem_memread_i, wb_regwrite_i;
  logic [3:0] opforward_o;
  logic stall_o, bubble_o;
`ifdef BRANCH_HAZARD_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  branch_fwd_hazard_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_branch_i(id_branch_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i),
    .mem_rd_i(mem_rd_i), .mem_regwrite_i(mem_regwrite_i), .mem_memread_i(mem_memread_i),
    .wb_rd_i(wb_rd_i), .wb_regwrite_i(wb_regwrite_i),
    .flush_i(flush_i),
    .opforward_o(opforward_o), .stall_o(stall_o), .bubble_o(bubble_o)
`ifdef BRANCH_HAZARD_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  // Model state: stall cycles still owed by an in-flight load-use, and stall total.
  int          rem = 0;
  logic [31:0] perf = '0;

  // Mux code indexed by rs1_src*3 + rs2_src, with 0=regfile, 1=MEM, 2=WB.
  int fwd_tbl[9] = '{0, 4, 8, 3, 1, 10, 5, 9, 2};

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, flush: 1'b0, br: 1'b0, use2: 1'b0, rs1: 5'd0, rs2: 5'd0,
          exrd: 5'd0, exw: 1'b0, exl: 1'b0, memrd: 5'd0, memw: 1'b0, meml: 1'b0,
          wbrd: 5'd0, wbw: 1'b0};
    return s;
  endfunction

  function automatic int src_of(input logic [4:0] r, input stim_t s);
    if (r == 0) return 0;
    if (s.memw && s.memrd == r && !s.meml) return 1;
    if (s.wbw && s.wbrd == r) return 2;
    return 0;
  endfunction

  function automatic int need_of(input logic [4:0] r, input stim_t s);
    if (r == 0) return 0;
    if (s.exw && s.exrd == r) return s.exl ? 2 : 1;
    if (s.memw && s.memrd == r && s.meml) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    int   a, b, n;
    @(posedge clk);
    #1;
    rst_i = s.rst; flush_i = s.flush; id_branch_i = s.br; id_use_rs2_i = s.use2;
    id_rs1_i = s.rs1; id_rs2_i = s.rs2;
    ex_rd_i = s.exrd; ex_regwrite_i = s.exw; ex_memread_i = s.exl;
    mem_rd_i = s.memrd; mem_regwrite_i = s.memw; mem_memread_i = s.meml;
    wb_rd_i = s.wbrd; wb_regwrite_i = s.wbw;

    a = s.br ? src_of(s.rs1, s) : 0;
    b = (s.br && s.use2) ? src_of(s.rs2, s) : 0;
    e.fwd = s.br ? 4'(fwd_tbl[a*3 + b]) : 4'd0;
    n = 0;
    if (s.br) n = need_of(s.rs1, s);
    if (s.br && s.use2 && need_of(s.rs2, s) > n) n = need_of(s.rs2, s);
    e.perf = perf;
    e.chk_perf = !s.rst;
    if (s.rst || s.flush) begin
      e.stall = 1'b0;
      rem = 0;
    end else if (rem > 0) begin
      e.stall = 1'b1;
      rem--;
    end else begin
      e.stall = (n != 0);
      rem = (n > 0) ? n - 1 : 0;
    end
    if (s.rst) perf = '0;
    else if (e.stall) perf = perf + 1;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("opforward", 32'(opforward_o), 32'(e.fwd));
        chk("stall", 32'(stall_o), 32'(e.stall));
        chk("bubble", 32'(bubble_o), 32'(e.stall));
`ifdef BRANCH_HAZARD_PERF_EN
        if (e.chk_perf) chk("stall_cnt", stall_cnt_o, e.perf);
`endif
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    repeat (3) step(s);

    // MEM ALU result to rs1, WB to rs2
    s = idle(); s.br = 1; s.use2 = 1; s.rs1 = 5; s.rs2 = 6;
    s.memrd = 5; s.memw = 1; s.wbrd = 6; s.wbw = 1;
    step(s);

    // Two-cycle load-use on rs2, then the load value arrives via WB
    for (int k = 0; k < 2; k++) begin
      s = idle(); s.br = 1; s.use2 = 1; s.rs1 = 1; s.rs2 = 7;
      s.exrd = 7; s.exw = 1; s.exl = 1;
      step(s); step(s);
      s.exrd = 0; s.exw = 0; s.exl = 0; s.wbrd = 7; s.wbw = 1;
      step(s);
    end

    // x0 never forwards or stalls
    s = idle(); s.br = 1; s.use2 = 1; s.exrd = 0; s.exw = 1; s.exl = 1;
    step(s);

    // JALR ignores its rs2 field
    s = idle(); s.br = 1; s.use2 = 0; s.rs1 = 1; s.rs2 = 3; s.memrd = 3; s.memw = 1;
    step(s);

    // MEM wins over WB
    s = idle(); s.br = 1; s.use2 = 1; s.rs1 = 9; s.rs2 = 9;
    s.memrd = 9; s.memw = 1; s.wbrd = 9; s.wbw = 1;
    step(s);

    // Flush in the HOLD cycle, then a hazard-free cycle must not stall
    s = idle(); s.br = 1; s.use2 = 1; s.rs1 = 4; s.exrd = 4; s.exw = 1; s.exl = 1;
    step(s);
    s.flush = 1; step(s);
    s = idle(); s.br = 1; s.rs1 = 2; step(s);

    // Reset clears the stall counter
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s);

    // ALU-in-EX and load-in-MEM single stalls
    s = idle(); s.br = 1; s.use2 = 1; s.rs1 = 3; s.rs2 = 2; s.exrd = 3; s.exw = 1;
    step(s);
    s = idle(); s.br = 1; s.use2 = 1; s.rs1 = 3; s.rs2 = 2; s.memrd = 2; s.memw = 1; s.meml = 1;
    step(s);

    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) == 0);
      s.flush = ($urandom_range(0, 11) == 0);
      s.br    = ($urandom_range(0, 3) != 0);
      s.use2  = 1'($urandom);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.exrd  = 5'($urandom_range(0, 3));
      s.exw   = 1'($urandom);
      s.exl   = 1'($urandom);
      s.memrd = 5'($urandom_range(0, 3));
      s.memw  = 1'($urandom);
      s.meml  = 1'($urandom);
      s.wbrd  = 5'($urandom_range(0, 3));
      s.wbw   = 1'($urandom);
      step(s);
    end

    repeat (3) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
